// File: rtl/gcd_snapshot_pkg.sv
// Shared constants and helpers for the GCD result snapshot block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Word map: one 32-word region per captured bus; region 0 also carries the
// status word at offset 0, so Bezout A starts at word 1.
package gcd_snapshot_pkg;

    localparam int OPERAND_W  = 1284;
    localparam int DATA_W     = 64;
    localparam int NWORDS     = 21;

    localparam int STATUS_W   = 0;
    localparam int BEZA_BASE  = 1;
    localparam int BEZB_BASE  = 32;
    localparam int DBG_BASE   = 64;
    localparam int DBG_STRIDE = 32;
    localparam int NDBG       = 6;

    // Status word: {32'h0, count, 14'b0, overflow, valid}
    function automatic logic [63:0] pack_status(input logic [15:0] count,
                                                input logic        overflow,
                                                input logic        valid);
        return {32'h0, count, 14'h0, overflow, valid};
    endfunction

endpackage

// File: rtl/gcd_snapshot_bank.sv
// One captured OPERAND_W-bit register with load enable and 64-bit word read mux.
// Latency: load takes effect on the next clk edge; rd_dat is combinational.
// Backpressure: none, load accepted every cycle.
//
// Ports: clk/rst (async active-high), load, din, word_sel (word within the
// operand, out-of-range selects read 0), rd_dat.
module gcd_snapshot_bank #(
    parameter int OPERAND_W = 1284,
    parameter int DATA_W    = 64,
    parameter int NWORDS    = 21
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [OPERAND_W-1:0] din,
    input  logic [4:0]           word_sel,
    output logic [DATA_W-1:0]    rd_dat
);

    localparam int PAD_W = NWORDS * DATA_W - OPERAND_W;

    logic [OPERAND_W-1:0]     data_q;
    logic [OPERAND_W-1:0]     data_d;
    logic [NWORDS*DATA_W-1:0] padded;

    always_comb begin
        data_d = load ? din : data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    // Zero-extend so the top word reads the partial bits with zero fill.
    assign padded = {{PAD_W{1'b0}}, data_q};

    always_comb begin
        rd_dat = '0;
        if (int'(word_sel) < NWORDS) begin
            rd_dat = padded[int'(word_sel)*DATA_W +: DATA_W];
        end
    end

endmodule

// File: rtl/gcd_result_snapshot.sv
// Captures GCD Bezout results (and optional debug buses) on DONE rise; serves them over SRAM port.
// Latency: capture 1 cycle after DONE sampled high; read data registered, 1 cycle.
// Backpressure: none, one SRAM access accepted every cycle.
//
// Ports: CLK, RESET (async active-high); SRAM_CEn/ADDR/WEn/WDATA/WBEn in,
// SRAM_RDATA out; DONE, BEZOUT_A/B, DEBUG_A/B/U/Y/L/N in; IRQ out (= valid).
// Macro GCD_SNAPSHOT_DEBUG_EN: when defined, the six DEBUG_* buses are
// captured too and mapped at words 64+32*k; otherwise those words read 0.
module gcd_result_snapshot
    import gcd_snapshot_pkg::*;
#(
    parameter int OPERAND_W = 1284,
    parameter int DATA_W    = 64,
    parameter int NWORDS    = gcd_snapshot_pkg::NWORDS
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 SRAM_CEn,
    input  logic [31:0]          SRAM_ADDR,
    input  logic                 SRAM_WEn,
    input  logic [DATA_W-1:0]    SRAM_WDATA,
    input  logic [7:0]           SRAM_WBEn,
    output logic [DATA_W-1:0]    SRAM_RDATA,
    input  logic                 DONE,
    input  logic [OPERAND_W-1:0] BEZOUT_A,
    input  logic [OPERAND_W-1:0] BEZOUT_B,
    input  logic [OPERAND_W-1:0] DEBUG_A,
    input  logic [OPERAND_W-1:0] DEBUG_B,
    input  logic [OPERAND_W-1:0] DEBUG_U,
    input  logic [OPERAND_W-1:0] DEBUG_Y,
    input  logic [OPERAND_W-1:0] DEBUG_L,
    input  logic [OPERAND_W-1:0] DEBUG_N,
    output logic                 IRQ
);

    logic              done_q,     done_d;
    logic              valid_q,    valid_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       count_q,    count_d;
    logic [DATA_W-1:0] rdata_q,    rdata_d;

    logic [8:0]        word_idx;
    logic [3:0]        region;
    logic [4:0]        offset;
    logic              cap;
    logic              ack;
    logic              rd_vld;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] beza_rd;
    logic [DATA_W-1:0] bezb_rd;

    // Each bus owns a 32-word region; the word index splits into region/offset.
    assign word_idx = SRAM_ADDR[11:3];
    assign region   = word_idx[8:5];
    assign offset   = word_idx[4:0];

    assign cap    = DONE && !done_q;
    assign rd_vld = !SRAM_CEn && SRAM_WEn;
    assign ack    = !SRAM_CEn && !SRAM_WEn && (word_idx == 9'(STATUS_W))
                    && !SRAM_WBEn[0] && SRAM_WDATA[0];

    gcd_snapshot_bank #(.OPERAND_W(OPERAND_W), .DATA_W(DATA_W), .NWORDS(NWORDS)) u_bank_a (
        .clk      (CLK),
        .rst      (RESET),
        .load     (cap),
        .din      (BEZOUT_A),
        .word_sel (offset - 5'(BEZA_BASE)),
        .rd_dat   (beza_rd)
    );

    gcd_snapshot_bank #(.OPERAND_W(OPERAND_W), .DATA_W(DATA_W), .NWORDS(NWORDS)) u_bank_b (
        .clk      (CLK),
        .rst      (RESET),
        .load     (cap),
        .din      (BEZOUT_B),
        .word_sel (offset),
        .rd_dat   (bezb_rd)
    );

`ifdef GCD_SNAPSHOT_DEBUG_EN
    logic [OPERAND_W-1:0] dbg_in [NDBG];
    logic [DATA_W-1:0]    dbg_rd [NDBG];
    logic [2:0]           dbg_idx;

    assign dbg_in[0] = DEBUG_A;
    assign dbg_in[1] = DEBUG_B;
    assign dbg_in[2] = DEBUG_U;
    assign dbg_in[3] = DEBUG_Y;
    assign dbg_in[4] = DEBUG_L;
    assign dbg_in[5] = DEBUG_N;
    assign dbg_idx   = 3'(region - 4'(DBG_BASE / DBG_STRIDE));

    for (genvar k = 0; k < NDBG; k++) begin : g_dbg
        gcd_snapshot_bank #(.OPERAND_W(OPERAND_W), .DATA_W(DATA_W), .NWORDS(NWORDS)) u_bank_dbg (
            .clk      (CLK),
            .rst      (RESET),
            .load     (cap),
            .din      (dbg_in[k]),
            .word_sel (offset),
            .rd_dat   (dbg_rd[k])
        );
    end
`else
    logic unused_dbg;
    assign unused_dbg = ^{DEBUG_A, DEBUG_B, DEBUG_U, DEBUG_Y, DEBUG_L, DEBUG_N};
`endif

    logic unused_sram;
    assign unused_sram = ^{SRAM_ADDR[31:12], SRAM_ADDR[2:0], SRAM_WDATA[DATA_W-1:1], SRAM_WBEn[7:1]};

    always_comb begin
        rd_word = '0;
        if (region == 4'(STATUS_W / DBG_STRIDE)) begin
            rd_word = (offset == 5'(STATUS_W)) ? pack_status(count_q, overflow_q, valid_q) : beza_rd;
        end else if (region == 4'(BEZB_BASE / DBG_STRIDE)) begin
            rd_word = bezb_rd;
        end
`ifdef GCD_SNAPSHOT_DEBUG_EN
        else if (region >= 4'(DBG_BASE / DBG_STRIDE) && region < 4'(DBG_BASE / DBG_STRIDE + NDBG)) begin
            rd_word = dbg_rd[dbg_idx];
        end
`endif
    end

    // Capture beats acknowledge for valid; an acknowledge always clears
    // overflow, even when it coincides with a capture onto a valid bank.
    always_comb begin
        done_d     = DONE;
        valid_d    = cap ? 1'b1 : (ack ? 1'b0 : valid_q);
        overflow_d = ack ? 1'b0 : ((cap && valid_q) ? 1'b1 : overflow_q);
        count_d    = cap ? count_q + 16'd1 : count_q;
        rdata_d    = rd_vld ? rd_word : rdata_q;
    end

    // done_q resets high so a DONE held across reset release is not a capture.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            done_q     <= 1'b1;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            count_q    <= '0;
            rdata_q    <= '0;
        end else begin
            done_q     <= done_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            count_q    <= count_d;
            rdata_q    <= rdata_d;
        end
    end

    assign SRAM_RDATA = rdata_q;
    assign IRQ        = valid_q;

endmodule
